// File: rtl/hls_chn_o_multi_wait_ctrl_if.sv
// Output-channel bundle between the HLS core FSM, the wait controller and the downstream pins.
// The master side is the core plus the downstream consumer; the slave side is the wait controller.
interface hls_chn_o_multi_wait_ctrl_if #(
    parameter int NCHN = 4,
    parameter int DW   = 16,
    parameter int CW   = 8
);
    logic                 core_wen;
    logic                 core_wten;
    logic [NCHN-1:0]      chn_o_oswt;
    logic [NCHN-1:0]      chn_o_iswt0;
    logic [NCHN-1:0]      chn_o_ld_core_psct;
    logic [NCHN*DW-1:0]   chn_o_din;
    logic [NCHN-1:0]      chn_o_rdy;
    logic [NCHN-1:0]      chn_o_vld;
    logic [NCHN*DW-1:0]   chn_o_dout;
    logic [NCHN-1:0]      chn_o_biwt;
    logic [NCHN-1:0]      chn_o_bdwt;
    logic [NCHN-1:0]      chn_o_ld_core_sct;
    logic                 core_stall;
    logic [NCHN*CW-1:0]   stall_cnt;
    logic                 stall_cnt_clr;

    modport master (
        output core_wen, core_wten, chn_o_oswt, chn_o_iswt0, chn_o_ld_core_psct,
               chn_o_din, chn_o_rdy, stall_cnt_clr,
        input  chn_o_vld, chn_o_dout, chn_o_biwt, chn_o_bdwt, chn_o_ld_core_sct,
               core_stall, stall_cnt
    );

    modport slave (
        input  core_wen, core_wten, chn_o_oswt, chn_o_iswt0, chn_o_ld_core_psct,
               chn_o_din, chn_o_rdy, stall_cnt_clr,
        output chn_o_vld, chn_o_dout, chn_o_biwt, chn_o_bdwt, chn_o_ld_core_sct,
               core_stall, stall_cnt
    );
endinterface

// File: rtl/hls_chn_o_multi_wait_ctrl.sv
// Per-channel write-pending tracker for HLS output channels, with an optional one-entry
// skid buffer per channel and saturating per-channel stall counters.
module hls_chn_o_multi_wait_ctrl #(
    parameter int NCHN = 4,
    parameter int DW   = 16,
    parameter int SKID = 1,
    parameter int CW   = 8
) (
    input logic                        nvdla_core_clk,
    input logic                        nvdla_core_rstn,
    hls_chn_o_multi_wait_ctrl_if.slave chn
);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [NCHN-1:0] pdswt0;
    logic [NCHN-1:0] ogwt;
    logic [NCHN-1:0] icwt;
    logic [NCHN-1:0] biwt;
    logic [NCHN-1:0] vld;
    logic [NCHN-1:0] stall;
    logic [NCHN-1:0] skid_full;
    logic [DW-1:0]   skid_dat  [NCHN];
    logic [CW-1:0]   stall_cnt [NCHN];

    assign pdswt0 = chn.chn_o_iswt0 & ~{NCHN{chn.core_wten}};
    assign ogwt   = pdswt0 | icwt;
    assign stall  = ogwt & ~biwt;

    // The skid entry always goes out before any newer write, keeping beats in order.
    generate
        if (SKID != 0) begin : g_skid
            assign vld  = skid_full | ogwt;
            assign biwt = ogwt & ~skid_full;
        end else begin : g_wait
            assign vld  = ogwt;
            assign biwt = ogwt & chn.chn_o_rdy;
        end
    endgenerate

    assign chn.chn_o_vld         = vld;
    assign chn.chn_o_biwt        = biwt;
    assign chn.chn_o_bdwt        = chn.chn_o_oswt & {NCHN{chn.core_wen}};
    assign chn.chn_o_ld_core_sct = chn.chn_o_ld_core_psct & ogwt;
    assign chn.core_stall        = |stall;

    // Data is forced to zero whenever the channel is idle so din never leaks as X.
    always_comb begin
        chn.chn_o_dout = '0;
        chn.stall_cnt  = '0;
        for (int c = 0; c < NCHN; c++) begin
            if (skid_full[c])
                chn.chn_o_dout[c*DW +: DW] = skid_dat[c];
            else if (vld[c])
                chn.chn_o_dout[c*DW +: DW] = chn.chn_o_din[c*DW +: DW];
            chn.stall_cnt[c*CW +: CW] = stall_cnt[c];
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            icwt      <= '0;
            skid_full <= '0;
            for (int c = 0; c < NCHN; c++) begin
                skid_dat[c]  <= '0;
                stall_cnt[c] <= '0;
            end
        end else begin
            icwt <= stall;
            for (int c = 0; c < NCHN; c++) begin
                if (SKID != 0) begin
                    if (biwt[c] && !chn.chn_o_rdy[c]) begin
                        skid_full[c] <= 1'b1;
                        skid_dat[c]  <= chn.chn_o_din[c*DW +: DW];
                    end else if (skid_full[c] && chn.chn_o_rdy[c]) begin
                        skid_full[c] <= 1'b0;
                    end
                end
                if (chn.stall_cnt_clr)
                    stall_cnt[c] <= '0;
                else if (stall[c] && stall_cnt[c] != CNT_MAX)
                    stall_cnt[c] <= stall_cnt[c] + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_hls_chn_o_multi_wait_ctrl.sv
// Directed bench: a wait-mode instance (SKID=0, CW=4) and a skid instance (SKID=1, CW=8),
// with a beat scoreboard per instance popped by a monitor on every vld&rdy.
module tb_hls_chn_o_multi_wait_ctrl;
    logic clk = 1'b0;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] d;
    } beat_t;

    beat_t qw[$];
    beat_t qs[$];

    always #5 clk = ~clk;

    hls_chn_o_multi_wait_ctrl_if #(.NCHN(4), .DW(16), .CW(4)) iw ();
    hls_chn_o_multi_wait_ctrl_if #(.NCHN(4), .DW(16), .CW(8)) is ();

    hls_chn_o_multi_wait_ctrl #(.NCHN(4), .DW(16), .SKID(0), .CW(4)) dut_w (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_b),
        .chn            (iw)
    );

    hls_chn_o_multi_wait_ctrl #(.NCHN(4), .DW(16), .SKID(1), .CW(8)) dut_s (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_b),
        .chn            (is)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_pop(input int which, input int c, input logic [15:0] d);
        beat_t e;
        beat_t a;
        a.ch = 2'(c);
        a.d  = d;
        if ((which == 0 && qw.size() == 0) || (which == 1 && qs.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat dut%0d: got ch%0d data %h expected none", which, c, d);
        end else begin
            e = (which == 0) ? qw.pop_front() : qs.pop_front();
            check(which == 0 ? "beat_w" : "beat_s", 64'(a), 64'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            for (int c = 0; c < 4; c++) begin
                if (iw.chn_o_vld[c] && iw.chn_o_rdy[c]) mon_pop(0, c, iw.chn_o_dout[c*16 +: 16]);
                if (is.chn_o_vld[c] && is.chn_o_rdy[c]) mon_pop(1, c, is.chn_o_dout[c*16 +: 16]);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_b = 1'b0;
        iw.core_wen = 0; iw.core_wten = 0; iw.chn_o_oswt = 0; iw.chn_o_iswt0 = 0;
        iw.chn_o_ld_core_psct = 0; iw.chn_o_rdy = 0; iw.stall_cnt_clr = 0;
        iw.chn_o_din = {4{16'hFFFF}};
        is.core_wen = 0; is.core_wten = 0; is.chn_o_oswt = 0; is.chn_o_iswt0 = 0;
        is.chn_o_ld_core_psct = 0; is.chn_o_rdy = 0; is.stall_cnt_clr = 0;
        is.chn_o_din = {4{16'hFFFF}};

        mid();
        check("rst_w_vld",   iw.chn_o_vld, 0);
        check("rst_w_dout",  iw.chn_o_dout, 0);
        check("rst_w_stall", iw.core_stall, 0);
        check("rst_w_cnt",   iw.stall_cnt, 0);
        check("rst_s_vld",   is.chn_o_vld, 0);
        check("rst_s_dout",  is.chn_o_dout, 0);
        check("rst_s_biwt",  is.chn_o_biwt, 0);
        check("rst_s_cnt",   is.stall_cnt, 0);

        @(posedge clk);
        #1;
        rst_b = 1'b1;
        iw.chn_o_din = '0;
        is.chn_o_din = '0;
        nxt();

        // wait mode: one request, three cycles of back-pressure
        iw.chn_o_iswt0 = 4'b0001; iw.chn_o_din[15:0] = 16'hBEEF;
        iw.chn_o_ld_core_psct = 4'hF; iw.chn_o_oswt = 4'b0101; iw.core_wen = 1;
        qw.push_back('{ch: 2'd0, d: 16'hBEEF});
        mid();
        check("t1_vld_c1",   iw.chn_o_vld, 4'b0001);
        check("t1_biwt_c1",  iw.chn_o_biwt, 0);
        check("t1_stall_c1", iw.core_stall, 1);
        check("t1_sct",      iw.chn_o_ld_core_sct, 4'b0001);
        check("t1_bdwt",     iw.chn_o_bdwt, 4'b0101);
        nxt();
        iw.chn_o_iswt0 = 0; iw.chn_o_ld_core_psct = 0; iw.chn_o_oswt = 0; iw.core_wen = 0;
        for (int i = 0; i < 2; i++) begin
            mid();
            check("t1_vld_hold",  iw.chn_o_vld, 4'b0001);
            check("t1_biwt_hold", iw.chn_o_biwt, 0);
            nxt();
        end
        iw.chn_o_rdy = 4'b0001;
        mid();
        check("t1_vld_c4",  iw.chn_o_vld, 4'b0001);
        check("t1_biwt_c4", iw.chn_o_biwt, 4'b0001);
        nxt();
        mid();
        check("t1_vld_done", iw.chn_o_vld, 0);
        check("t1_cnt",      iw.stall_cnt[3:0], 3);
        iw.chn_o_rdy = 0;

        // skid mode: accepted immediately, held in skid across two not-ready cycles
        nxt();
        is.chn_o_iswt0 = 4'b0001; is.chn_o_din[15:0] = 16'h1234; is.chn_o_rdy = 0;
        qs.push_back('{ch: 2'd0, d: 16'h1234});
        mid();
        check("t2_biwt_c1",  is.chn_o_biwt, 4'b0001);
        check("t2_stall_c1", is.core_stall, 0);
        check("t2_dout_c1",  is.chn_o_dout[15:0], 16'h1234);
        nxt();
        is.chn_o_iswt0 = 0; is.chn_o_din = '0;
        mid();
        check("t2_vld_c2",   is.chn_o_vld, 4'b0001);
        check("t2_dout_c2",  is.chn_o_dout[15:0], 16'h1234);
        check("t2_biwt_c2",  is.chn_o_biwt, 0);
        check("t2_stall_c2", is.core_stall, 0);
        nxt();
        is.chn_o_rdy = 4'b0001;
        mid();
        check("t2_dout_c3", is.chn_o_dout[15:0], 16'h1234);
        nxt();
        mid();
        check("t2_vld_done", is.chn_o_vld, 0);

        // skid drain while a new write arrives: the new write slips one cycle
        nxt();
        is.chn_o_rdy = 0; is.chn_o_iswt0 = 4'b0001; is.chn_o_din[15:0] = 16'hAAAA;
        qs.push_back('{ch: 2'd0, d: 16'hAAAA});
        mid();
        check("t3_biwt_fill", is.chn_o_biwt, 4'b0001);
        nxt();
        is.chn_o_din[15:0] = 16'h5555; is.chn_o_rdy = 4'b0001;
        qs.push_back('{ch: 2'd0, d: 16'h5555});
        mid();
        check("t3_dout_drain",  is.chn_o_dout[15:0], 16'hAAAA);
        check("t3_biwt_drain",  is.chn_o_biwt, 0);
        check("t3_stall_drain", is.core_stall, 1);
        nxt();
        is.chn_o_iswt0 = 0;
        mid();
        check("t3_dout_next",  is.chn_o_dout[15:0], 16'h5555);
        check("t3_biwt_next",  is.chn_o_biwt, 4'b0001);
        check("t3_stall_next", is.core_stall, 0);
        nxt();
        mid();
        check("t3_vld_done", is.chn_o_vld, 0);

        // streaming with rdy held high on channel 2
        nxt();
        is.chn_o_rdy = 4'hF;
        for (int i = 0; i < 8; i++) begin
            is.chn_o_iswt0 = 4'b0100;
            is.chn_o_din[47:32] = 16'h0100 + 16'(i);
            qs.push_back('{ch: 2'd2, d: 16'h0100 + 16'(i)});
            mid();
            check("t4_biwt",  is.chn_o_biwt, 4'b0100);
            check("t4_stall", is.core_stall, 0);
            nxt();
        end
        is.chn_o_iswt0 = 0;
        mid();
        check("t4_vld_done", is.chn_o_vld, 0);
        check("t4_cnt",      is.stall_cnt, 32'h0000_0001);
        is.chn_o_rdy = 0;

        // wten blocks new requests but a pending write still completes
        nxt();
        iw.chn_o_rdy = 0; iw.chn_o_iswt0 = 4'b0010; iw.chn_o_din[31:16] = 16'h7777;
        qw.push_back('{ch: 2'd1, d: 16'h7777});
        mid();
        check("t5_vld_c1",  iw.chn_o_vld, 4'b0010);
        check("t5_biwt_c1", iw.chn_o_biwt, 0);
        nxt();
        iw.core_wten = 1;
        mid();
        check("t5_vld_c2",  iw.chn_o_vld, 4'b0010);
        check("t5_biwt_c2", iw.chn_o_biwt, 0);
        nxt();
        iw.chn_o_rdy = 4'b0010;
        mid();
        check("t5_biwt_c3", iw.chn_o_biwt, 4'b0010);
        nxt();
        mid();
        check("t5_vld_blocked",  iw.chn_o_vld, 0);
        check("t5_biwt_blocked", iw.chn_o_biwt, 0);
        check("t5_cnt",          iw.stall_cnt, 16'h0023);
        nxt();
        iw.core_wten = 0; iw.chn_o_iswt0 = 0; iw.chn_o_rdy = 0;

        // saturation, clear, then reset mid-stall
        iw.chn_o_iswt0 = 4'b1000; iw.chn_o_din[63:48] = 16'h3333;
        repeat (20) nxt();
        mid();
        check("t6_cnt_sat", iw.stall_cnt, 16'hF023);
        nxt();
        iw.stall_cnt_clr = 1;
        is.chn_o_rdy = 0; is.chn_o_iswt0 = 4'b1000; is.chn_o_din[63:48] = 16'hC3C3;
        nxt();
        iw.stall_cnt_clr = 0;
        is.chn_o_din[63:48] = 16'hDEAD;
        mid();
        check("t6_cnt_clr",    iw.stall_cnt, 0);
        check("t6_s_vld",      is.chn_o_vld, 4'b1000);
        check("t6_s_biwt",     is.chn_o_biwt, 0);
        check("t6_s_dout",     is.chn_o_dout[63:48], 16'hC3C3);
        check("t6_s_stall",    is.core_stall, 1);
        nxt();
        mid();
        check("t6_cnt_after", iw.stall_cnt, 16'h1000);
        rst_b = 1'b0;
        iw.chn_o_iswt0 = 0;
        is.chn_o_iswt0 = 0;
        #1;
        check("t6_rst_w_vld",   iw.chn_o_vld, 0);
        check("t6_rst_w_stall", iw.core_stall, 0);
        check("t6_rst_s_vld",   is.chn_o_vld, 0);
        check("t6_rst_s_dout",  is.chn_o_dout, 0);
        check("t6_rst_s_cnt",   is.stall_cnt, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        nxt();
        mid();
        check("t6_post_s_vld", is.chn_o_vld, 0);
        check("t6_post_w_vld", iw.chn_o_vld, 0);

        check("qw_empty", 64'(qw.size()), 0);
        check("qs_empty", 64'(qs.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
